// File: rtl/fp_vector_mult_share_pkg.sv
// Shared types, constants and helpers for the shared vector-multiplier responder.
// Optional statistics counters are enabled with FP_VECTOR_MULT_SHARE_STATS_EN.
package fp_share_pkg;

  localparam int DEF_NUM_CLIENTS = 2;
  localparam int MAX_CLIENTS     = 32;
  localparam int STAT_CNT_W      = 32;

  typedef logic [DEF_NUM_CLIENTS-1:0] client_onehot_t;

  function automatic int unsigned popcount(input logic [MAX_CLIENTS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CLIENTS; i++) n += 32'(v[i]);
    return n;
  endfunction

  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + STAT_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/fp_multiplier.sv
// IEEE-754 single-precision multiplier lane (round-to-nearest-even, denormals flushed)
// with a fixed LATENCY-cycle result/valid pipeline.
module fp_multiplier #(
  parameter int LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        out_valid
);

  logic [31:0] res;
  logic [31:0] data_q  [LATENCY];
  logic [31:0] data_d  [LATENCY];
  logic        valid_q [LATENCY];
  logic        valid_d [LATENCY];

  always_comb begin
    logic        sign, guard_b, sticky;
    logic        a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;
    logic [47:0] prod;
    logic [22:0] frac;
    logic [23:0] frac_r;
    int          exp_i;
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_spec = (a[30:23] == 8'hFF);
    b_spec = (b[30:23] == 8'hFF);
    a_nan  = a_spec && (a[22:0] != '0);
    b_nan  = b_spec && (b[22:0] != '0);
    prod   = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    exp_i  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      frac    = prod[46:24];
      guard_b = prod[23];
      sticky  = |prod[22:0];
      exp_i   = exp_i + 1;
    end else begin
      frac    = prod[45:23];
      guard_b = prod[22];
      sticky  = |prod[21:0];
    end
    frac_r = {1'b0, frac} + 24'(guard_b && (sticky || frac[0]));
    if (frac_r[23]) exp_i = exp_i + 1;
    if (a_spec || b_spec)
      res = {sign, 8'hFF, (a_nan || b_nan || a_zero || b_zero) ? 23'h400000 : 23'h0};
    else if (a_zero || b_zero) res = {sign, 31'h0};
    else if (exp_i >= 255)     res = {sign, 8'hFF, 23'h0};
    else if (exp_i <= 0)       res = {sign, 31'h0};
    else                       res = {sign, exp_i[7:0], frac_r[22:0]};
  end

  always_comb begin
    data_d[0]  = res;
    valid_d[0] = in_ready;
    for (int i = 1; i < LATENCY; i++) begin
      data_d[i]  = data_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // NOTE: the data pipe is deliberately not reset; only the valid bits qualify it,
  // so resetting wide storage would cost reset fan-out for nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) valid_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++) valid_q[i] <= valid_d[i];
    end
  end

  assign out       = data_q[LATENCY-1];
  assign out_valid = valid_q[LATENCY-1];

endmodule

// File: rtl/fp_vector_mult_share_arbiter.sv
// Client arbiter: fixed priority (lowest index) or round-robin from a rotating pointer.
module fp_share_arbiter
  import fp_share_pkg::*;
#(
  parameter int NUM_CLIENTS     = 2,
  parameter int ARB_ROUND_ROBIN = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] grant
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // NOTE: found/idx are blocking temporaries evaluated in loop order inside the
  // combinational block; only the pointer register uses non-blocking updates.
  always_comb begin
    int   start, idx;
    logic found;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    start = (ARB_ROUND_ROBIN != 0) ? int'(ptr_q) : 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = (start + i) % NUM_CLIENTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = PTR_W'((idx + 1) % NUM_CLIENTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_vector_mult_share.sv
// Shared vector-multiplier responder: arbitrates clients, tags results back to the issuer.
// Define FP_VECTOR_MULT_SHARE_STATS_EN to add grant/drop/busy statistics counters.
module fp_vector_mult_share
  import fp_share_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int NUM_INPUTS      = 5,
  parameter int NUM_CLIENTS     = 2,
  parameter int MULT_LATENCY    = 8,
  parameter int ARB_ROUND_ROBIN = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [WIDTH*NUM_INPUTS*NUM_CLIENTS-1:0] cl_in_a,
  input  logic [WIDTH*NUM_INPUTS*NUM_CLIENTS-1:0] cl_in_b,
  input  logic [NUM_CLIENTS-1:0]                  cl_in_ready,
  output logic [NUM_CLIENTS-1:0]                  cl_grant,
  output logic [WIDTH*NUM_INPUTS-1:0]             cl_out,
  output logic [NUM_CLIENTS-1:0]                  cl_out_valid,
  output logic                                    collision,
  output logic                                    align_err
`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
  ,
  output logic [STAT_CNT_W*NUM_CLIENTS-1:0]       stat_grants,
  output logic [STAT_CNT_W*NUM_CLIENTS-1:0]       stat_drops,
  output logic [STAT_CNT_W-1:0]                   stat_busy
`endif
);

  localparam int VEC_W   = WIDTH * NUM_INPUTS;
  localparam int GUARD_W = $clog2(MULT_LATENCY + 1);

  logic [VEC_W-1:0]       mux_a, mux_b;
  logic [NUM_INPUTS-1:0]  lane_valid;
  logic                   mult_ready, mult_valid, mult_valid_eff, guard_active;
  logic [NUM_CLIENTS-1:0] tag_q [MULT_LATENCY];
  logic [NUM_CLIENTS-1:0] tag_d [MULT_LATENCY];
  logic [GUARD_W-1:0]     guard_q, guard_d;
  logic                   collision_q, collision_d, align_err_q, align_err_d;

  fp_share_arbiter #(
    .NUM_CLIENTS     (NUM_CLIENTS),
    .ARB_ROUND_ROBIN (ARB_ROUND_ROBIN)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (cl_in_ready),
    .grant (cl_grant)
  );

  // NOTE: every combinational output is defaulted before the loop so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (cl_grant[k]) begin
        mux_a = mux_a | cl_in_a[k*VEC_W +: VEC_W];
        mux_b = mux_b | cl_in_b[k*VEC_W +: VEC_W];
      end
    end
  end

  assign mult_ready = |cl_in_ready;

  for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_lane
    fp_multiplier #(.LATENCY(MULT_LATENCY)) u_mul (
      .clk       (clk),
      .rst_n     (rst),
      .in_ready  (mult_ready),
      .a         (mux_a[j*WIDTH +: WIDTH]),
      .b         (mux_b[j*WIDTH +: WIDTH]),
      .out       (cl_out[j*WIDTH +: WIDTH]),
      .out_valid (lane_valid[j])
    );
  end

  assign mult_valid     = &lane_valid;
  // Multiplier output is untrusted until a full latency has elapsed since reset release.
  assign guard_active   = (guard_q != GUARD_W'(MULT_LATENCY));
  assign mult_valid_eff = mult_valid & ~guard_active;
  assign cl_out_valid   = tag_q[MULT_LATENCY-1] & {NUM_CLIENTS{mult_valid_eff}};
  assign collision      = collision_q;
  assign align_err      = align_err_q;

  always_comb begin
    tag_d[0] = cl_grant;
    for (int i = 1; i < MULT_LATENCY; i++) tag_d[i] = tag_q[i-1];
    guard_d     = guard_active ? guard_q + GUARD_W'(1) : guard_q;
    collision_d = collision_q | (popcount(MAX_CLIENTS'(cl_in_ready)) > 1);
    align_err_d = align_err_q | (mult_valid_eff != (|tag_q[MULT_LATENCY-1]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MULT_LATENCY; i++) tag_q[i] <= '0;
      guard_q     <= '0;
      collision_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < MULT_LATENCY; i++) tag_q[i] <= tag_d[i];
      guard_q     <= guard_d;
      collision_q <= collision_d;
      align_err_q <= align_err_d;
    end
  end

`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
  logic [STAT_CNT_W-1:0] grants_q [NUM_CLIENTS];
  logic [STAT_CNT_W-1:0] grants_d [NUM_CLIENTS];
  logic [STAT_CNT_W-1:0] drops_q  [NUM_CLIENTS];
  logic [STAT_CNT_W-1:0] drops_d  [NUM_CLIENTS];
  logic [STAT_CNT_W-1:0] busy_q, busy_d;

  always_comb begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      grants_d[k] = sat_inc(grants_q[k], cl_grant[k]);
      drops_d[k]  = sat_inc(drops_q[k], cl_in_ready[k] & ~cl_grant[k]);
    end
    busy_d = sat_inc(busy_q, mult_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        grants_q[k] <= '0;
        drops_q[k]  <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        grants_q[k] <= grants_d[k];
        drops_q[k]  <= drops_d[k];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_stat
    assign stat_grants[k*STAT_CNT_W +: STAT_CNT_W] = grants_q[k];
    assign stat_drops[k*STAT_CNT_W +: STAT_CNT_W]  = drops_q[k];
  end
  assign stat_busy = busy_q;
`endif

endmodule

// File: tb/tb_fp_vector_mult_share.sv
// Self-checking bench: fixed-priority and round-robin instances driven in parallel
// and compared against a real-arithmetic scoreboard of expected results per cycle.
module tb_fp_vector_mult_share;
  import fp_share_pkg::*;

  localparam int L  = 8;
  localparam int NI = 2;
  localparam int NC = 2;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  in_a, in_b;
  logic [1:0]    rdy;
  logic [1:0]    g_fp, g_rr, v_fp, v_rr;
  logic [63:0]   out_fp, out_rr;
  logic          col_fp, col_rr, ae_fp, ae_rr;
`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
  logic [63:0]   sg_fp, sd_fp, sg_rr, sd_rr;
  logic [31:0]   sb_fp, sb_rr;
`endif

  always #5 clk = ~clk;

  fp_vector_mult_share #(.WIDTH(32), .NUM_INPUTS(NI), .NUM_CLIENTS(NC),
                         .MULT_LATENCY(L), .ARB_ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst), .cl_in_a(in_a), .cl_in_b(in_b), .cl_in_ready(rdy),
    .cl_grant(g_fp), .cl_out(out_fp), .cl_out_valid(v_fp),
    .collision(col_fp), .align_err(ae_fp)
`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
    , .stat_grants(sg_fp), .stat_drops(sd_fp), .stat_busy(sb_fp)
`endif
  );

  fp_vector_mult_share #(.WIDTH(32), .NUM_INPUTS(NI), .NUM_CLIENTS(NC),
                         .MULT_LATENCY(L), .ARB_ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst(rst), .cl_in_a(in_a), .cl_in_b(in_b), .cl_in_ready(rdy),
    .cl_grant(g_rr), .cl_out(out_rr), .cl_out_valid(v_rr),
    .collision(col_rr), .align_err(ae_rr)
`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
    , .stat_grants(sg_rr), .stat_drops(sd_rr), .stat_busy(sb_rr)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  int ptr_m = 0;
  int obs_v1 = 0;
  logic coll_m = 1'b0;
  client_onehot_t last_gr;
  client_onehot_t exp_v_fp [DEPTH];
  client_onehot_t exp_v_rr [DEPTH];
  logic [63:0]    exp_d_fp [DEPTH];
  logic [63:0]    exp_d_rr [DEPTH];

  typedef struct {
    logic [1:0]  r;
    logic [63:0] a0, b0, a1, b1;
    logic [1:0]  g_fp;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  function automatic real f32_to_real(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'h00) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    m = m * (2.0 ** e);
    return f[31] ? -m : m;
  endfunction

  // Only exactly representable products are generated, so truncation is exact.
  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [63:0] mul_vec(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int j = 0; j < NI; j++)
      r[j*32 +: 32] = real_to_f32(f32_to_real(a[j*32 +: 32]) * f32_to_real(b[j*32 +: 32]));
    return r;
  endfunction

  function automatic logic [31:0] fi(input int v);
    return real_to_f32(real'(v));
  endfunction

  function automatic logic [63:0] rnd_vec();
    logic [63:0] r;
    int v;
    for (int j = 0; j < NI; j++) begin
      v = int'($urandom_range(1, 4000));
      if ($urandom_range(0, 1) == 1) v = -v;
      r[j*32 +: 32] = fi(v);
    end
    return r;
  endfunction

`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
  int sm_g0, sm_g1, sm_d0, sm_d1, sm_busy;
`endif

  task automatic check_out();
    check("valid_fp", 64'(v_fp), 64'(exp_v_fp[t]));
    if (exp_v_fp[t] != 0) check("data_fp", out_fp, exp_d_fp[t]);
    check("valid_rr", 64'(v_rr), 64'(exp_v_rr[t]));
    if (exp_v_rr[t] != 0) check("data_rr", out_rr, exp_d_rr[t]);
    check("collision_fp", 64'(col_fp), 64'(coll_m));
    check("collision_rr", 64'(col_rr), 64'(coll_m));
    check("align_err_fp", 64'(ae_fp), 64'(0));
    check("align_err_rr", 64'(ae_rr), 64'(0));
    if (v_fp == 2'b10) obs_v1++;
  endtask

  task automatic cycle(input logic [1:0] r, input logic [63:0] a0, input logic [63:0] b0,
                       input logic [63:0] a1, input logic [63:0] b1);
    client_onehot_t gf, gr;
    int p;
    rdy  = r;
    in_a = {a1, a0};
    in_b = {b1, b0};
    gf = '0;
    if (r[0]) gf = 2'b01;
    else if (r[1]) gf = 2'b10;
    gr = '0;
    for (int i = 0; i < NC; i++) begin
      p = (ptr_m + i) % NC;
      if (gr == 0 && r[p]) gr[p] = 1'b1;
    end
    #1;
    check("grant_fp", 64'(g_fp), 64'(gf));
    check("grant_rr", 64'(g_rr), 64'(gr));
    last_gr = gr;
    if (gf != 0) begin
      exp_v_fp[t+L] = gf;
      exp_d_fp[t+L] = gf[0] ? mul_vec(a0, b0) : mul_vec(a1, b1);
    end
    if (gr != 0) begin
      exp_v_rr[t+L] = gr;
      exp_d_rr[t+L] = gr[0] ? mul_vec(a0, b0) : mul_vec(a1, b1);
      ptr_m = gr[0] ? 1 : 0;
    end
    if ($countones(r) > 1) coll_m = 1'b1;
`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
    if (gf[0]) sm_g0++;
    if (gf[1]) sm_g1++;
    if (r[0] && !gf[0]) sm_d0++;
    if (r[1] && !gf[1]) sm_d1++;
    if (r != 0) sm_busy++;
`endif
    @(posedge clk);
    t++;
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    rdy = 2'b00;
    for (int i = t; i < DEPTH; i++) begin
      exp_v_fp[i] = '0;
      exp_v_rr[i] = '0;
    end
    coll_m = 1'b0;
    ptr_m  = 0;
`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
    sm_g0 = 0; sm_g1 = 0; sm_d0 = 0; sm_d1 = 0; sm_busy = 0;
`endif
    #1;
    check("rst_valid_fp", 64'(v_fp), 64'(0));
    check("rst_valid_rr", 64'(v_rr), 64'(0));
    check("rst_collision", 64'(col_fp), 64'(0));
    check("rst_align_err", 64'(ae_fp), 64'(0));
    repeat (n) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      check("rst_hold_valid_fp", 64'(v_fp), 64'(0));
      check("rst_hold_valid_rr", 64'(v_rr), 64'(0));
    end
    rst = 1'b1;
  endtask

  initial begin
    client_onehot_t rr_pat [4];
    rst  = 1'b0;
    rdy  = 2'b00;
    in_a = '0;
    in_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_v_fp[i] = '0; exp_v_rr[i] = '0; exp_d_fp[i] = '0; exp_d_rr[i] = '0;
    end
    rr_pat[0] = 2'b01; rr_pat[1] = 2'b10; rr_pat[2] = 2'b01; rr_pat[3] = 2'b10;

    tbl[0] = '{r: 2'b01, a0: {fi(3), fi(5)}, b0: {fi(7), fi(-2)}, a1: 64'h0, b1: 64'h0, g_fp: 2'b01};
    tbl[1] = '{r: 2'b10, a0: 64'h0, b0: 64'h0, a1: {fi(11), fi(13)}, b1: {fi(17), fi(19)}, g_fp: 2'b10};
    tbl[2] = '{r: 2'b11, a0: {fi(4), fi(6)}, b0: {fi(8), fi(9)}, a1: {fi(100), fi(1)}, b1: {fi(2), fi(3)}, g_fp: 2'b01};
    tbl[3] = '{r: 2'b00, a0: {fi(1), fi(1)}, b0: {fi(1), fi(1)}, a1: {fi(1), fi(1)}, b1: {fi(1), fi(1)}, g_fp: 2'b00};
    tbl[4] = '{r: 2'b11, a0: {fi(-25), fi(30)}, b0: {fi(40), fi(50)}, a1: {fi(2), fi(2)}, b1: {fi(2), fi(2)}, g_fp: 2'b01};
    tbl[5] = '{r: 2'b10, a0: 64'h0, b0: 64'h0, a1: {fi(1000), fi(-3)}, b1: {fi(1000), fi(-3)}, g_fp: 2'b10};

    @(negedge clk);
    do_reset(2);

    // Single request at cycle 10, expected back on client 0 at cycle 18 only.
    while (t < 10) idle(1);
    cycle(2'b01, {32'h3FC00000, 32'h40000000}, {32'h40800000, 32'h40400000}, 64'h0, 64'h0);
    while (t < 18) idle(1);
    check("plan_valid_c18", 64'(v_fp), 64'(2'b01));
    check("plan_data_c18", out_fp, 64'h40C0000040C00000);
    idle(1);
    check("plan_valid_c19", 64'(v_fp), 64'(0));
    check("plan_collision", 64'(col_fp), 64'(0));

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].r, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      check($sformatf("tbl_grant_%0d", i), 64'(g_fp), 64'(tbl[i].g_fp));
    end
    idle(L + 1);
    check("tbl_collision_sticky", 64'(col_fp), 64'(1));

    obs_v1 = 0;
    for (int k = 1; k <= 20; k++)
      cycle(2'b10, 64'h0, 64'h0, {fi(k + 100), fi(k)}, {fi(1), fi(1)});
    idle(L + 1);
    check("stream_count", 64'(obs_v1), 64'(20));

    // In-flight requests are discarded by a mid-flight reset.
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(2'b01, rnd_vec(), rnd_vec(), 64'h0, 64'h0);
    do_reset(2);
    idle(L + 2);
    check("midrst_align_err", 64'(ae_fp | ae_rr), 64'(0));
    check("midrst_collision", 64'(col_fp | col_rr), 64'(0));

    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
      check($sformatf("rr_grant_%0d", i), 64'(last_gr), 64'(rr_pat[i]));
    end
    idle(L + 1);
    check("rr_collision", 64'(col_rr), 64'(1));

`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
    do_reset(1);
    cycle(2'b01, rnd_vec(), rnd_vec(), 64'h0, 64'h0);
    cycle(2'b11, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    cycle(2'b01, rnd_vec(), rnd_vec(), 64'h0, 64'h0);
    check("stat_grants0", 64'(sg_fp[31:0]), 64'(3));
    check("stat_drops1", 64'(sd_fp[63:32]), 64'(1));
    check("stat_busy", 64'(sb_fp), 64'(3));
`endif

    for (int i = 0; i < 300; i++)
      cycle(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    idle(L + 2);

`ifdef FP_VECTOR_MULT_SHARE_STATS_EN
    check("stat_model_g0", 64'(sg_fp[31:0]), 64'(sm_g0));
    check("stat_model_g1", 64'(sg_fp[63:32]), 64'(sm_g1));
    check("stat_model_d0", 64'(sd_fp[31:0]), 64'(sm_d0));
    check("stat_model_d1", 64'(sd_fp[63:32]), 64'(sm_d1));
    check("stat_model_busy", 64'(sb_fp), 64'(sm_busy));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
